// File: rtl/ldvio_pkg.sv
// rtl/ldvio_pkg.sv - shared types and sizes for the load-violation predictor update path
package ldvio_pkg;

   localparam int LDVIO_PRED_LOG = 7;
   localparam int LDVIO_PC_W     = 32;
   localparam int LDVIO_OFS      = 2;
   localparam int LDVIO_TAG_W    = LDVIO_PC_W - LDVIO_PRED_LOG - LDVIO_OFS;

   typedef struct packed {
      logic [LDVIO_PRED_LOG-1:0] idx;
      logic [LDVIO_TAG_W-1:0]    tag;
   } ldvio_upd_t;

   typedef enum logic {
      NORMAL = 1'b0,
      FLUSH  = 1'b1
   } ldvio_state_t;

endpackage

// File: rtl/ldvio_upd_fifo.sv
// rtl/ldvio_upd_fifo.sv - register FIFO of pending predictor updates
// with a parallel compare against every live entry for deduplication.
module ldvio_upd_fifo
   import ldvio_pkg::*;
#(
   parameter int QDEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push_i,
   input  ldvio_upd_t pushData_i,
   input  logic       pop_i,
   output ldvio_upd_t head_o,
   output logic       full_o,
   output logic       empty_o,
   input  ldvio_upd_t matchData_i,
   output logic       match_o
);

   localparam int AW = $clog2(QDEPTH);

   logic [AW:0]       wrPtr;
   logic [AW:0]       rdPtr;
   ldvio_upd_t        mem [QDEPTH];
   logic [QDEPTH-1:0] slotValid;

   assign empty_o = (wrPtr == rdPtr);
   assign full_o  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
   assign head_o  = mem[rdPtr[AW-1:0]];

   always_comb begin
      match_o = 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
         if (slotValid[i] && (mem[i] == matchData_i)) match_o = 1'b1;
      end
   end

   // When full, push and pop hit the same slot; the push must leave it valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         slotValid <= '0;
      end else begin
         if (pop_i) begin
            rdPtr                       <= rdPtr + (AW+1)'(1);
            slotValid[rdPtr[AW-1:0]]    <= 1'b0;
         end
         if (push_i) begin
            mem[wrPtr[AW-1:0]]          <= pushData_i;
            slotValid[wrPtr[AW-1:0]]    <= 1'b1;
            wrPtr                       <= wrPtr + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/ld_vio_pred_update.sv
// rtl/ld_vio_pred_update.sv - queues load-violation updates into the predictor write port
// and sequences index-walk flushes of the valid RAM.
module ld_vio_pred_update
   import ldvio_pkg::*;
#(
   parameter int PRED_LOG     = LDVIO_PRED_LOG,
   parameter int PC_W         = LDVIO_PC_W,
   parameter int OFS          = LDVIO_OFS,
   parameter int QDEPTH       = 4,
   parameter int FLUSH_PERIOD = 16384
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       loadViolation_i,
   input  logic                       recoverFlag_i,
   input  logic [PC_W-1:0]            recoverPC_i,
   input  logic                       flushReq_i,
   output logic [PRED_LOG-1:0]        predWrAddr_o,
   output logic [PC_W-PRED_LOG-OFS-1:0] predWrTag_o,
   output logic                       predWrValid_o,
   output logic                       predWe_o,
   output logic                       flushActive_o,
   output logic [7:0]                 dropCnt_o
);

   localparam int CNT_W = (FLUSH_PERIOD > 0) ? $clog2(FLUSH_PERIOD + 1) : 1;
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'((FLUSH_PERIOD > 0) ? FLUSH_PERIOD - 1 : 0);

   ldvio_state_t        state;
   logic [CNT_W-1:0]    periodCnt;
   logic [PRED_LOG-1:0] walkIdx;

   ldvio_upd_t evEntry;
   ldvio_upd_t headEntry;
   logic       ev;
   logic       fifoFull;
   logic       fifoEmpty;
   logic       fifoMatch;
   logic       inFlightMatch;
   logic       isDup;
   logic       periodHit;
   logic       flushStart;
   logic       pop;
   logic       push;
   logic       dropEv;

   assign ev          = loadViolation_i & recoverFlag_i;
   assign evEntry.idx = recoverPC_i[PRED_LOG+OFS-1:OFS];
   assign evEntry.tag = recoverPC_i[PC_W-1:PRED_LOG+OFS];

   // The entry being written this cycle has just left the FIFO but is still
   // treated as pending, so a burst of identical events yields one write.
   assign inFlightMatch = predWe_o && predWrValid_o &&
                          (predWrAddr_o == evEntry.idx) && (predWrTag_o == evEntry.tag);
   assign isDup         = fifoMatch || inFlightMatch;

   assign periodHit  = (FLUSH_PERIOD != 0) && (periodCnt == PERIOD_LAST);
   assign flushStart = (state == NORMAL) && (flushReq_i || periodHit);
   assign pop        = (state == NORMAL) && !flushStart && !fifoEmpty;
   assign push       = ev && !isDup && (!fifoFull || pop);
   assign dropEv     = ev && !isDup && fifoFull && !pop;

   ldvio_upd_fifo #(
      .QDEPTH (QDEPTH)
   ) updFifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push),
      .pushData_i  (evEntry),
      .pop_i       (pop),
      .head_o      (headEntry),
      .full_o      (fifoFull),
      .empty_o     (fifoEmpty),
      .matchData_i (evEntry),
      .match_o     (fifoMatch)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= NORMAL;
         periodCnt     <= '0;
         walkIdx       <= '0;
         predWe_o      <= 1'b0;
         predWrAddr_o  <= '0;
         predWrTag_o   <= '0;
         predWrValid_o <= 1'b0;
         flushActive_o <= 1'b0;
         dropCnt_o     <= '0;
      end else begin
         predWe_o      <= 1'b0;
         flushActive_o <= 1'b0;
         if (dropEv && (dropCnt_o != 8'hFF)) dropCnt_o <= dropCnt_o + 8'd1;
         case (state)
            NORMAL: begin
               if (flushStart) begin
                  state     <= FLUSH;
                  walkIdx   <= '0;
                  periodCnt <= '0;
               end else begin
                  if (FLUSH_PERIOD != 0) periodCnt <= periodCnt + CNT_W'(1);
                  if (pop) begin
                     predWe_o      <= 1'b1;
                     predWrAddr_o  <= headEntry.idx;
                     predWrTag_o   <= headEntry.tag;
                     predWrValid_o <= 1'b1;
                  end
               end
            end
            FLUSH: begin
               predWe_o      <= 1'b1;
               flushActive_o <= 1'b1;
               predWrAddr_o  <= walkIdx;
               predWrTag_o   <= '0;
               predWrValid_o <= 1'b0;
               walkIdx       <= walkIdx + PRED_LOG'(1);
               if (walkIdx == '1) state <= NORMAL;
            end
            default: state <= NORMAL;
         endcase
      end
   end

endmodule
